// File: rtl/breakout_pkg.sv
// Shared types and constants for the Breakout score/lives engine.
// The state encodings are visible on the score_counter state port.
package breakout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_SERVE     = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    localparam int SCORE_W   = 14;
    // 9 bits covers the largest single-edge addition: a 240-point hit plus the 100-point level bonus.
    localparam int ADD_W     = 9;
    localparam int MAX_SCORE = 9999;

endpackage

// File: rtl/score_counter_sat_adder.sv
// Saturating score adder.
// Forms the 15-bit sum, clamps it to MAX_SCORE, and flags whether the result differs from base.
module sat_adder
    import breakout_pkg::*;
(
    input  logic [SCORE_W-1:0] base,
    input  logic [ADD_W-1:0]   addend,
    output logic [SCORE_W-1:0] result,
    output logic               changed
);

    logic [SCORE_W:0] sum;

    assign sum = {1'b0, base} + (SCORE_W+1)'(addend);

    always_comb begin
        result = sum[SCORE_W-1:0];
        if (sum > (SCORE_W+1)'(MAX_SCORE)) begin
            result = SCORE_W'(MAX_SCORE);
        end
        changed = (result != base);
    end

endmodule

// File: rtl/score_counter.sv
// Breakout score/lives engine: turns gameplay event pulses into a saturating score,
// a combo multiplier, a lives count and a game-state FSM. All outputs are registered.
module score_counter
    import breakout_pkg::*;
#(
    parameter int ROWS        = 6,
    parameter int POINTS_STEP = 10,
    parameter int COMBO_MAX   = 4,
    parameter int LEVEL_BONUS = 100,
    parameter int START_LIVES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         brick_hit,
    input  logic [2:0]   hit_row,
    input  logic         paddle_hit,
    input  logic         ball_lost,
    input  logic         bricks_cleared,
    output logic [13:0]  score,
    output logic [1:0]   lives,
    output logic [2:0]   combo,
    output logic [1:0]   state,
    output logic         score_upd
);

    game_state_t        cur_state;
    logic               brick_valid;
    logic [ADD_W-1:0]   row_weight;
    logic [ADD_W-1:0]   hit_pts;
    logic [ADD_W-1:0]   addend;
    logic [SCORE_W-1:0] sum_result;
    logic               sum_changed;

    // A brick in an out-of-range row scores nothing and does not advance the combo.
    assign brick_valid = brick_hit && ({1'b0, hit_row} < 4'(ROWS));
    assign row_weight  = ADD_W'(ROWS) - ADD_W'(hit_row);
    assign hit_pts     = row_weight * ADD_W'(POINTS_STEP) * ADD_W'(combo);
    assign addend      = (brick_valid    ? hit_pts              : '0)
                       + (bricks_cleared ? ADD_W'(LEVEL_BONUS)  : '0);

    sat_adder u_sat_adder (
        .base    (score),
        .addend  (addend),
        .result  (sum_result),
        .changed (sum_changed)
    );

    assign state = cur_state;

    // Combo uses its pre-edge value for scoring, then resets on any paddle/lost/cleared event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
            score     <= '0;
            lives     <= '0;
            combo     <= 3'd1;
            score_upd <= 1'b0;
        end else begin
            score_upd <= 1'b0;
            case (cur_state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        cur_state <= ST_PLAYING;
                        score     <= '0;
                        lives     <= 2'(START_LIVES);
                        combo     <= 3'd1;
                        score_upd <= (score != '0);
                    end
                end
                ST_SERVE: begin
                    if (start) begin
                        cur_state <= ST_PLAYING;
                    end
                end
                ST_PLAYING: begin
                    score     <= sum_result;
                    score_upd <= sum_changed;
                    if (paddle_hit || ball_lost || bricks_cleared) begin
                        combo <= 3'd1;
                    end else if (brick_valid && (combo != 3'(COMBO_MAX))) begin
                        combo <= combo + 3'd1;
                    end
                    // Losing the ball takes priority over clearing the level.
                    if (ball_lost) begin
                        lives     <= lives - 2'd1;
                        cur_state <= (lives == 2'd1) ? ST_GAME_OVER : ST_SERVE;
                    end else if (bricks_cleared) begin
                        cur_state <= ST_SERVE;
                    end
                end
                default: cur_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: a table of directed vectors with hand-computed
// expectations, followed by hand-written reset and saturation sequences.
module tb_score_counter;

    typedef struct {
        logic        start;
        logic        brick;
        logic [2:0]  row;
        logic        paddle;
        logic        lost;
        logic        cleared;
        logic [13:0] exp_score;
        logic [1:0]  exp_lives;
        logic [2:0]  exp_combo;
        logic [1:0]  exp_state;
        logic        exp_upd;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        brick_hit;
    logic [2:0]  hit_row;
    logic        paddle_hit;
    logic        ball_lost;
    logic        bricks_cleared;
    logic [13:0] score;
    logic [1:0]  lives;
    logic [2:0]  combo;
    logic [1:0]  state;
    logic        score_upd;

    int total = 0;
    int bad   = 0;
    vec_t vecs[30];

    score_counter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .brick_hit      (brick_hit),
        .hit_row        (hit_row),
        .paddle_hit     (paddle_hit),
        .ball_lost      (ball_lost),
        .bricks_cleared (bricks_cleared),
        .score          (score),
        .lives          (lives),
        .combo          (combo),
        .state          (state),
        .score_upd      (score_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic s, input logic b, input logic [2:0] r,
                                 input logic p, input logic l, input logic c);
        @(negedge clk);
        start          = s;
        brick_hit      = b;
        hit_row        = r;
        paddle_hit     = p;
        ball_lost      = l;
        bricks_cleared = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [13:0] es, input logic [1:0] el,
                               input logic [2:0] ec, input logic [1:0] est, input logic eu);
        total++;
        if ({score, lives, combo, state, score_upd} !== {es, el, ec, est, eu}) begin
            bad++;
            $display("[TB] FAIL %s: got score=%0d lives=%0d combo=%0d state=%0d upd=%0b, want score=%0d lives=%0d combo=%0d state=%0d upd=%0b",
                     name, score, lives, combo, state, score_upd, es, el, ec, est, eu);
        end
    endtask

    initial begin
        // start brick row paddle lost cleared | score lives combo state upd
        vecs[0]  = '{1,0,0,0,0,0,   0,3,1,1,0};
        vecs[1]  = '{0,1,0,0,0,0,  60,3,2,1,1};
        vecs[2]  = '{0,0,0,1,0,0,  60,3,1,1,0};
        vecs[3]  = '{0,1,5,0,0,0,  70,3,2,1,1};
        vecs[4]  = '{0,1,5,0,0,0,  90,3,3,1,1};
        vecs[5]  = '{0,1,5,0,0,0, 120,3,4,1,1};
        vecs[6]  = '{0,1,5,0,0,0, 160,3,4,1,1};
        vecs[7]  = '{0,1,5,0,0,0, 200,3,4,1,1};
        vecs[8]  = '{0,1,7,0,0,0, 200,3,4,1,0};
        vecs[9]  = '{0,1,6,0,0,0, 200,3,4,1,0};
        vecs[10] = '{0,0,0,1,0,0, 200,3,1,1,0};
        vecs[11] = '{0,1,5,0,0,0, 210,3,2,1,1};
        vecs[12] = '{0,1,5,0,0,0, 230,3,3,1,1};
        vecs[13] = '{0,1,2,0,1,1, 450,2,1,2,1};
        vecs[14] = '{0,1,0,0,0,0, 450,2,1,2,0};
        vecs[15] = '{1,0,0,0,0,0, 450,2,1,1,0};
        vecs[16] = '{1,0,0,0,0,0, 450,2,1,1,0};
        vecs[17] = '{0,0,0,0,0,1, 550,2,1,2,1};
        vecs[18] = '{1,0,0,0,0,0, 550,2,1,1,0};
        vecs[19] = '{0,0,0,0,1,0, 550,1,1,2,0};
        vecs[20] = '{1,0,0,0,0,0, 550,1,1,1,0};
        vecs[21] = '{0,0,0,0,1,0, 550,0,1,3,0};
        vecs[22] = '{0,1,0,0,0,0, 550,0,1,3,0};
        vecs[23] = '{1,0,0,0,0,0,   0,3,1,1,1};
        vecs[24] = '{0,1,1,0,0,0,  50,3,2,1,1};
        vecs[25] = '{0,0,0,0,1,0,  50,2,1,2,0};
        vecs[26] = '{1,0,0,0,0,0,  50,2,1,1,0};
        vecs[27] = '{0,0,0,0,1,0,  50,1,1,2,0};
        vecs[28] = '{1,0,0,0,0,0,  50,1,1,1,0};
        vecs[29] = '{0,1,2,0,1,1, 190,0,1,3,1};

        rst_n = 1'b0;
        start = 0; brick_hit = 0; hit_row = 0; paddle_hit = 0; ball_lost = 0; bricks_cleared = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 0, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            applyStimulus(vecs[i].start, vecs[i].brick, vecs[i].row,
                          vecs[i].paddle, vecs[i].lost, vecs[i].cleared);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_score, vecs[i].exp_lives,
                        vecs[i].exp_combo, vecs[i].exp_state, vecs[i].exp_upd);
        end

        // Synchronous reset mid-game wins over a simultaneous brick hit.
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("restart", 0, 3, 1, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("pre_reset_hit", 60, 3, 2, 1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        brick_hit = 1'b1;
        hit_row = 3'd0;
        @(posedge clk);
        #1;
        checkOutput("mid_reset", 0, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        brick_hit = 1'b0;

        // Build up to 9990 with combo pinned at 1, then cross the ceiling.
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("sat_start", 0, 3, 1, 1, 0);
        for (int i = 0; i < 166; i++) begin
            applyStimulus(0, 1, 0, 1, 0, 0);
        end
        checkOutput("sat_9960", 9960, 3, 1, 1, 1);
        applyStimulus(0, 1, 3, 1, 0, 0);
        checkOutput("sat_9990", 9990, 3, 1, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("sat_clamp", 9999, 3, 2, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("sat_hold", 9999, 3, 3, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("sat_bonus", 9999, 3, 1, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
